// File: rtl/cpri_rx_rd_sched.sv
// -----------------------------------------------------------------------------
// cpri_rx_rd_sched
//   Read-side scheduler for a bank of LANE_NUM CPRI receive symbol buffers.
//   Waits until every active lane holds a complete symbol, then reads one
//   symbol (SYM_LEN words) from all active lanes in lock-step, stalling on
//   downstream back-pressure. Between bursts it idles GAP_CYCLES cycles so
//   each buffer can swap pages. Tracks word / symbol-in-slot / total symbol
//   counts and flags lanes that fail to align within TIMEOUT cycles.
//
// Ports
//   i_clk           processing clock
//   i_reset         asynchronous active-high reset
//   i_enable        scheduler run enable
//   i_lane_mask     lanes taking part (latched on IDLE -> WAIT_VLD)
//   i_lane_rd_vld   per-lane "full symbol available"
//   i_ds_ready      downstream accepts a beat this cycle
//   i_err_clr       clears the sticky timeout error and releases ERR
//   o_rd_en         per-lane read enable (combinational, beat-aligned)
//   o_burst_start   first beat of a burst
//   o_burst_last    last beat of a burst
//   o_word_cnt      index of the current beat
//   o_sym_idx       symbol index within the slot
//   o_sym_cnt       total symbols completed (wrapping)
//   o_busy          scheduler not in IDLE
//   o_timeout_err   sticky lane-alignment error
//   o_err_lanes     active lanes that were not valid at timeout
// -----------------------------------------------------------------------------
module cpri_rx_rd_sched #(
    parameter int LANE_NUM      = 4,
    parameter int SYM_LEN       = 3168,
    parameter int CNT_WIDTH     = 12,
    parameter int GAP_CYCLES    = 8,
    parameter int SYMS_PER_SLOT = 14,
    parameter int TIMEOUT       = 4095,
    parameter int TO_WIDTH      = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [LANE_NUM-1:0]  i_lane_mask,
    input  logic [LANE_NUM-1:0]  i_lane_rd_vld,
    input  logic                 i_ds_ready,
    input  logic                 i_err_clr,
    output logic [LANE_NUM-1:0]  o_rd_en,
    output logic                 o_burst_start,
    output logic                 o_burst_last,
    output logic [CNT_WIDTH-1:0] o_word_cnt,
    output logic [3:0]           o_sym_idx,
    output logic [15:0]          o_sym_cnt,
    output logic                 o_busy,
    output logic                 o_timeout_err,
    output logic [LANE_NUM-1:0]  o_err_lanes
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_READ = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(SYM_LEN - 1);
    localparam logic [TO_WIDTH-1:0]  TO_MAX    = TO_WIDTH'(TIMEOUT);
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]           SYM_LAST  = 4'(SYMS_PER_SLOT - 1);

    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [LANE_NUM-1:0]  amask_r;
    logic [CNT_WIDTH-1:0] word_cnt_r;
    logic [3:0]           sym_idx_r;
    logic [15:0]          sym_cnt_r;
    logic [TO_WIDTH-1:0]  to_cnt_r;
    logic [TO_WIDTH-1:0]  to_cnt_nxt_s;
    logic [GAP_W-1:0]     gap_cnt_r;
    logic                 err_r;
    logic [LANE_NUM-1:0]  err_lanes_r;

    logic [LANE_NUM-1:0]  vld_m_s;
    logic                 any_vld_s;
    logic                 all_vld_s;
    logic                 beat_s;
    logic                 last_beat_s;
    logic                 timeout_hit_s;

    assign vld_m_s     = i_lane_rd_vld & amask_r;
    assign any_vld_s   = |vld_m_s;
    assign all_vld_s   = (vld_m_s == amask_r);
    assign beat_s      = (state_r == ST_READ) & i_ds_ready;
    assign last_beat_s = beat_s & (word_cnt_r == LAST_WORD);

    // Timeout counter next value: counts only while lanes are partially valid,
    // restarts whenever no active lane is valid, saturates at TIMEOUT.
    always_comb begin
        to_cnt_nxt_s = to_cnt_r;
        if (!any_vld_s) begin
            to_cnt_nxt_s = '0;
        end else if (!all_vld_s && (to_cnt_r != TO_MAX)) begin
            to_cnt_nxt_s = to_cnt_r + TO_WIDTH'(1);
        end else begin
            to_cnt_nxt_s = to_cnt_r;
        end
    end

    // The error fires on the cycle the counter would reach TIMEOUT, so
    // WAIT_VLD lasts exactly TIMEOUT partially-valid cycles.
    assign timeout_hit_s = (to_cnt_nxt_s == TO_MAX);

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_enable && (i_lane_mask != '0)) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!i_enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_ERR;
                end else if (all_vld_s) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_READ: begin
                // Enable is ignored here: a burst always runs to completion.
                if (last_beat_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s = i_enable ? ST_WAIT : ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            ST_ERR: begin
                if (i_err_clr) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and active-lane mask capture.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            amask_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_WAIT)) begin
                amask_r <= i_lane_mask;
            end
        end
    end

    // Word counter: advances only on a beat so stalls leave no address gap.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word_cnt_r <= '0;
        end else if (last_beat_s) begin
            word_cnt_r <= '0;
        end else if (beat_s) begin
            word_cnt_r <= word_cnt_r + CNT_WIDTH'(1);
        end
    end

    // Symbol counters: only i_reset clears them; IDLE and ERR leave them alone.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sym_idx_r <= 4'd0;
            sym_cnt_r <= 16'd0;
        end else if (last_beat_s) begin
            sym_idx_r <= (sym_idx_r == SYM_LAST) ? 4'd0 : (sym_idx_r + 4'd1);
            sym_cnt_r <= sym_cnt_r + 16'd1;
        end
    end

    // Timeout and gap counters, both cleared whenever their state is left.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            to_cnt_r  <= '0;
            gap_cnt_r <= '0;
        end else begin
            if ((state_r == ST_WAIT) && (state_nxt_s == ST_WAIT)) begin
                to_cnt_r <= to_cnt_nxt_s;
            end else begin
                to_cnt_r <= '0;
            end
            if ((state_r == ST_GAP) && (state_nxt_s == ST_GAP)) begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end else begin
                gap_cnt_r <= '0;
            end
        end
    end

    // Sticky error flag and lane snapshot; a new timeout beats a clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            err_r       <= 1'b0;
            err_lanes_r <= '0;
        end else if ((state_r == ST_WAIT) && (state_nxt_s == ST_ERR)) begin
            err_r       <= 1'b1;
            err_lanes_r <= amask_r & ~i_lane_rd_vld;
        end else if (i_err_clr) begin
            err_r       <= 1'b0;
            err_lanes_r <= '0;
        end
    end

    assign o_rd_en       = {LANE_NUM{beat_s}} & amask_r;
    assign o_burst_start = beat_s & (word_cnt_r == '0);
    assign o_burst_last  = last_beat_s;
    assign o_word_cnt    = word_cnt_r;
    assign o_sym_idx     = sym_idx_r;
    assign o_sym_cnt     = sym_cnt_r;
    assign o_busy        = (state_r != ST_IDLE);
    assign o_timeout_err = err_r;
    assign o_err_lanes   = err_lanes_r;

endmodule

// File: tb/tb_cpri_rx_rd_sched.sv
module tb_cpri_rx_rd_sched;

    localparam int LN  = 4;
    localparam int SL  = 3168;
    localparam int CW  = 12;
    localparam int GC  = 8;
    localparam int SPS = 14;
    localparam int TO  = 4095;
    localparam int TW  = 12;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic [LN-1:0] i_lane_mask;
    logic [LN-1:0] i_lane_rd_vld;
    logic          i_ds_ready;
    logic          i_err_clr;
    logic [LN-1:0] o_rd_en;
    logic          o_burst_start;
    logic          o_burst_last;
    logic [CW-1:0] o_word_cnt;
    logic [3:0]    o_sym_idx;
    logic [15:0]   o_sym_cnt;
    logic          o_busy;
    logic          o_timeout_err;
    logic [LN-1:0] o_err_lanes;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the symbol counters: completed bursts since reset.
    int exp_idx = 0;
    int exp_cnt = 0;

    cpri_rx_rd_sched #(
        .LANE_NUM(LN), .SYM_LEN(SL), .CNT_WIDTH(CW), .GAP_CYCLES(GC),
        .SYMS_PER_SLOT(SPS), .TIMEOUT(TO), .TO_WIDTH(TW)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_lane_mask(i_lane_mask), .i_lane_rd_vld(i_lane_rd_vld),
        .i_ds_ready(i_ds_ready), .i_err_clr(i_err_clr),
        .o_rd_en(o_rd_en), .o_burst_start(o_burst_start),
        .o_burst_last(o_burst_last), .o_word_cnt(o_word_cnt),
        .o_sym_idx(o_sym_idx), .o_sym_cnt(o_sym_cnt), .o_busy(o_busy),
        .o_timeout_err(o_timeout_err), .o_err_lanes(o_err_lanes)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Burst completion in the model.
    task automatic model_sym_done();
        exp_idx = (exp_idx + 1) % SPS;
        exp_cnt = (exp_cnt + 1) % 65536;
    endtask

    // A cycle spent in IDLE with enable low.
    task automatic idle_step(input string ph);
        @(negedge i_clk);
        i_enable = 1'b0; i_lane_mask = 4'($urandom); i_lane_rd_vld = 4'($urandom);
        i_ds_ready = 1'($urandom); i_err_clr = 1'b0;
        #1;
        check_eq({ph, ":busy"}, o_busy, 0);
        check_eq({ph, ":rd_en"}, o_rd_en, 0);
        check_eq({ph, ":word_cnt"}, o_word_cnt, 0);
        check_eq({ph, ":sym_idx"}, o_sym_idx, exp_idx);
        check_eq({ph, ":sym_cnt"}, o_sym_cnt, exp_cnt);
        check_eq({ph, ":err"}, o_timeout_err, 0);
    endtask

    // IDLE cycle that requests a start with the given mask.
    task automatic launch(input logic [3:0] mask);
        @(negedge i_clk);
        i_enable = 1'b1; i_lane_mask = mask; i_lane_rd_vld = 4'($urandom);
        i_ds_ready = 1'($urandom); i_err_clr = 1'b0;
        #1;
        check_eq("launch:busy", o_busy, 0);
        check_eq("launch:rd_en", o_rd_en, 0);
    endtask

    // WAIT_VLD: n_partial cycles lacking at least one masked lane, then one full.
    task automatic wait_phase(input logic [3:0] mask, input int n_partial);
        logic [3:0] v;
        for (int i = 0; i <= n_partial; i++) begin
            @(negedge i_clk);
            v = 4'($urandom);
            if (i == n_partial) begin
                v = v | mask;
            end else if ((v & mask) == mask) begin
                v = v & ~mask;
            end
            i_enable = 1'b1; i_lane_rd_vld = v; i_lane_mask = 4'($urandom);
            i_ds_ready = 1'($urandom);
            #1;
            check_eq("wait:busy", o_busy, 1);
            check_eq("wait:rd_en", o_rd_en, 0);
            check_eq("wait:err", o_timeout_err, 0);
        end
    endtask

    // READ: mode 0 always ready, 1 toggling from ready, 2 random (75% ready).
    task automatic read_phase(input logic [3:0] mask, input int mode, input int drop_beat,
                              input int rst_beat, output int cycles);
        int k;
        bit rdy;
        bit aborted;
        k = 0; cycles = 0; aborted = 1'b0;
        while (k < SL && cycles < 4 * SL && !aborted) begin
            @(negedge i_clk);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cycles % 2 == 0);
                default: rdy = ($urandom_range(3, 0) != 0);
            endcase
            i_ds_ready = rdy; i_lane_rd_vld = 4'($urandom); i_lane_mask = 4'($urandom);
            if (k == drop_beat) i_enable = 1'b0;
            #1;
            check_eq("read:rd_en", o_rd_en, rdy ? mask : 4'b0000);
            check_eq("read:word_cnt", o_word_cnt, k);
            check_eq("read:start", o_burst_start, rdy && (k == 0));
            check_eq("read:last", o_burst_last, rdy && (k == SL - 1));
            check_eq("read:busy", o_busy, 1);
            check_eq("read:sym_idx", o_sym_idx, exp_idx);
            check_eq("read:sym_cnt", o_sym_cnt, exp_cnt);
            if (k == rst_beat) begin
                i_reset = 1'b1;
                #1;
                exp_idx = 0; exp_cnt = 0;
                check_eq("rst:rd_en", o_rd_en, 0);
                check_eq("rst:busy", o_busy, 0);
                check_eq("rst:word_cnt", o_word_cnt, 0);
                check_eq("rst:sym_idx", o_sym_idx, 0);
                check_eq("rst:sym_cnt", o_sym_cnt, 0);
                @(negedge i_clk);
                i_enable = 1'b0;
                i_reset = 1'b0;
                aborted = 1'b1;
            end else begin
                if (rdy) k++;
                cycles++;
            end
        end
        if (!aborted) begin
            check_eq("read:burst_bound", k, SL);
            model_sym_done();
        end
    endtask

    // GAP: GC idle cycles; next_en decides whether another wait follows.
    task automatic gap_phase(input bit next_en);
        for (int i = 0; i < GC; i++) begin
            @(negedge i_clk);
            i_enable = next_en; i_ds_ready = 1'($urandom);
            i_lane_rd_vld = 4'($urandom); i_lane_mask = 4'($urandom);
            #1;
            check_eq("gap:rd_en", o_rd_en, 0);
            check_eq("gap:busy", o_busy, 1);
            check_eq("gap:word_cnt", o_word_cnt, 0);
            check_eq("gap:last", o_burst_last, 0);
            check_eq("gap:sym_idx", o_sym_idx, exp_idx);
            check_eq("gap:sym_cnt", o_sym_cnt, exp_cnt);
        end
    endtask

    // Lane-alignment timeout with mask 0101, lane 2 valid, lane 0 never.
    task automatic timeout_test();
        logic [3:0] v;
        launch(4'b0101);
        for (int i = 0; i < 100 + 1 + TO; i++) begin
            @(negedge i_clk);
            v = 4'($urandom) & 4'b1010;
            if (i != 100) v = v | 4'b0100;
            i_enable = 1'b1; i_lane_rd_vld = v; i_ds_ready = 1'($urandom);
            i_lane_mask = 4'($urandom);
            #1;
            check_eq("to_wait:err", o_timeout_err, 0);
            check_eq("to_wait:busy", o_busy, 1);
            check_eq("to_wait:rd_en", o_rd_en, 0);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            i_enable = 1'($urandom); i_lane_rd_vld = 4'($urandom);
            i_err_clr = (i == 5);
            #1;
            check_eq("to_err:err", o_timeout_err, 1);
            check_eq("to_err:lanes", o_err_lanes, 4'b0001);
            check_eq("to_err:busy", o_busy, 1);
            check_eq("to_err:rd_en", o_rd_en, 0);
        end
        idle_step("to_clr");
        check_eq("to_clr:lanes", o_err_lanes, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [3:0] m;
        i_reset = 1'b1; i_enable = 1'b0; i_lane_mask = '0; i_lane_rd_vld = '0;
        i_ds_ready = 1'b0; i_err_clr = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        check_eq("reset:rd_en", o_rd_en, 0);
        check_eq("reset:busy", o_busy, 0);
        check_eq("reset:word_cnt", o_word_cnt, 0);
        check_eq("reset:sym_idx", o_sym_idx, 0);
        check_eq("reset:sym_cnt", o_sym_cnt, 0);
        check_eq("reset:err", o_timeout_err, 0);
        check_eq("reset:lanes", o_err_lanes, 0);
        check_eq("reset:start", o_burst_start, 0);
        check_eq("reset:last", o_burst_last, 0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Zero mask never leaves IDLE.
        launch(4'b0000);
        idle_step("mask0");

        // Enable dropped in WAIT_VLD returns to IDLE.
        launch(4'b0011);
        @(negedge i_clk);
        i_enable = 1'b0; i_lane_rd_vld = 4'b0001;
        #1;
        check_eq("wait_drop:busy", o_busy, 1);
        idle_step("wait_drop");

        // Full mask, always ready.
        launch(4'hF);
        wait_phase(4'hF, 0);
        read_phase(4'hF, 0, -1, -1, cyc);
        check_eq("t1:cycles", cyc, SL);
        gap_phase(1'b0);
        idle_step("t1");
        check_eq("t1:sym_idx", o_sym_idx, 1);

        // Toggling ready.
        launch(4'hF);
        wait_phase(4'hF, 2);
        read_phase(4'hF, 1, -1, -1, cyc);
        check_eq("t2:cycles", cyc, 2 * SL - 1);
        gap_phase(1'b0);
        idle_step("t2");

        // Random mask, random partial validity, random ready.
        m = 4'($urandom_range(15, 1));
        launch(m);
        wait_phase(m, $urandom_range(20, 0));
        read_phase(m, 2, -1, -1, cyc);
        gap_phase(1'b0);
        idle_step("t3");

        timeout_test();

        // Enable dropped at beat 100: burst completes, then IDLE.
        launch(4'hF);
        wait_phase(4'hF, 0);
        read_phase(4'hF, 0, 100, -1, cyc);
        check_eq("t5:cycles", cyc, SL);
        gap_phase(1'b0);
        idle_step("t5");

        // Reset at beat 500.
        launch(4'b1011);
        wait_phase(4'b1011, 0);
        read_phase(4'b1011, 0, -1, 500, cyc);
        idle_step("t6");

        // 15 back-to-back symbols.
        launch(4'hF);
        for (int n = 0; n < 15; n++) begin
            wait_phase(4'hF, 0);
            read_phase(4'hF, 0, -1, -1, cyc);
            gap_phase(n < 14);
        end
        idle_step("t7");
        check_eq("t7:sym_cnt", o_sym_cnt, 15);
        check_eq("t7:sym_idx", o_sym_idx, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpri_rx_rd_sched.md
Name: cpri_rx_rd_sched

Overview:
- Read-side scheduler for a bank of LANE_NUM CPRI receive symbol buffers. One buffer per antenna lane.
- Waits until every enabled lane holds a complete symbol, then reads one symbol from all enabled lanes in lock-step. The per-lane read enables stall whenever the downstream stage is not ready.
- Tracks word, symbol-in-slot and total symbol counts, and flags lanes that fail to align within a timeout.
- Sits between the buffer bank and the dimension-reduction datapath, in the i_clk domain.

Parameters:
- LANE_NUM, 4, number of buffer lanes scheduled.
- SYM_LEN, 3168, words read per lane per symbol.
- CNT_WIDTH, 12, width of the word counter; must satisfy 2^CNT_WIDTH > SYM_LEN.
- GAP_CYCLES, 8, idle cycles inserted between bursts so each buffer can clear rd_rdy and swap.
- SYMS_PER_SLOT, 14, symbols per slot; sets the symbol-index wrap point.
- TIMEOUT, 4095, WAIT_VLD cycles allowed with partial lane validity before an error.
- TO_WIDTH, 12, width of the timeout counter.

Ports:
- i_clk  in  1  processing clock.
- i_reset  in  1  reset; asynchronous, active-high.
- i_enable  in  1  scheduler run enable.
- i_lane_mask  in  LANE_NUM  1 = lane participates; sampled only in IDLE.
- i_lane_rd_vld  in  LANE_NUM  per-lane "full symbol available" (buffer o_rd_vld).
- i_ds_ready  in  1  downstream can accept a beat this cycle.
- i_err_clr  in  1  clears o_timeout_err and releases ERR.
- o_rd_en  out  LANE_NUM  per-lane read enable.
- o_burst_start  out  1  pulse on the first beat of a burst.
- o_burst_last  out  1  pulse on the last beat of a burst.
- o_word_cnt  out  CNT_WIDTH  index of the current beat, 0..SYM_LEN-1.
- o_sym_idx  out  4  symbol index in slot, 0..SYMS_PER_SLOT-1.
- o_sym_cnt  out  16  total symbols completed, wrapping.
- o_busy  out  1  high in any state other than IDLE.
- o_timeout_err  out  1  sticky lane-alignment error.
- o_err_lanes  out  LANE_NUM  snapshot of masked lanes NOT valid at timeout.

Behaviour:
- Reset: all outputs are 0, the state is IDLE and all counters are 0. Reset asserted mid-burst aborts the burst immediately; o_rd_en drops in the same cycle, since the reset is asynchronous.
- State machine:
  - IDLE → WAIT_VLD when i_enable=1 and i_lane_mask≠0; the mask is latched into the active-mask register (amask) on this transition. i_lane_mask=0 keeps the block in IDLE.
  - WAIT_VLD → READ on the cycle after (i_lane_rd_vld & amask)==amask and i_enable=1.
  - WAIT_VLD → IDLE when i_enable=0.
  - WAIT_VLD → ERR when the timeout counter reaches TIMEOUT.
  - READ → GAP after the beat with word_cnt==SYM_LEN-1.
  - GAP → WAIT_VLD after GAP_CYCLES cycles if i_enable=1; otherwise GAP → IDLE.
  - ERR → IDLE on i_err_clr=1.
- Timeout counter:
  - Counts only in WAIT_VLD while 0 < popcount(valid & amask) < popcount(amask).
  - Clears when no masked lane is valid and on leaving WAIT_VLD.
  - Saturates at TIMEOUT.
- o_rd_en is combinational: {LANE_NUM{state==READ & i_ds_ready}} & amask. A beat is a cycle with READ & i_ds_ready. word_cnt advances only on a beat, so a stall holds word_cnt and leaves no gap in buffer addressing.
- o_burst_start = beat & word_cnt==0. o_burst_last = beat & word_cnt==SYM_LEN-1. Both are combinational and aligned with o_rd_en.
- Word counter wrap: the last beat clears word_cnt to 0.
- Symbol counters, updated in the same edge as the last beat:
  - sym_idx increments and wraps SYMS_PER_SLOT-1 → 0.
  - sym_cnt increments and wraps at 16 bits.
- i_enable deasserted during READ: the burst still completes all SYM_LEN beats, then goes GAP → IDLE. Bursts are never truncated.
- An enabled lane dropping i_lane_rd_vld during READ is ignored. Validity is checked only in WAIT_VLD.
- i_lane_mask changes outside IDLE have no effect until the next IDLE → WAIT_VLD transition.
- Error handling:
  - On WAIT_VLD→ERR, o_timeout_err is set and o_err_lanes latches amask & ~i_lane_rd_vld.
  - Both hold until i_err_clr. If i_err_clr and a new timeout occur in the same cycle, the set wins.
- sym_idx and sym_cnt reset only on i_reset. They are not cleared by IDLE or by an error.

Test Plan:
- Mask=4'hF, all four lanes valid, i_ds_ready=1:
  - READ starts 1 cycle after validity.
  - 3168 consecutive beats with o_rd_en=4'hF.
  - o_burst_start on beat 0 and o_burst_last on beat 3167.
  - o_sym_idx 0→1, then GAP for 8 cycles.
- Same setup with i_ds_ready toggled 1/0 every cycle:
  - Burst spans 6335 cycles and o_word_cnt holds during stalls.
  - o_rd_en is 0 exactly in the not-ready cycles.
- Mask=4'b0101, lane 2 valid, lane 0 never valid:
  - Timeout after 4095 WAIT_VLD cycles; o_timeout_err=1, o_err_lanes=4'b0001.
  - i_err_clr → IDLE.
- 15 back-to-back symbols:
  - o_sym_idx sequence 0..13, then wraps to 0; o_sym_cnt=15.
- i_enable dropped at beat 100:
  - All 3168 beats still issued, GAP for 8 cycles, then IDLE with o_busy=0.
- i_reset pulsed at beat 500:
  - o_rd_en=0 immediately; state IDLE; o_word_cnt, o_sym_idx and o_sym_cnt all 0.
